imem_loadable: RTL and testbench
================================

# imem_loadable

Parametrised, run-time loadable instruction memory for the ARM single-cycle and pipelined cores. It replaces hardcoded ROM contents with a streaming load port that lets a testbench or boot host write a program word by word. It serves fetches through a fully pipelined read path with configurable latency. Each fetch reports misaligned and out-of-range faults instead of returning undefined data.

## Interface
- DATA_W, 32: instruction word width.
- DEPTH, 64: words of storage; power of two, 4..1024.
- LAT, 1: fetch latency in cycles; legal values 1..3.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low (0 = in reset).
- ld_start  in  1  pulse; abort everything and begin a new load at word 0.
- ld_valid  in  1  load word present.
- ld_last  in  1  qualifies ld_valid; marks the final program word.
- ld_data  in  DATA_W  load word.
- ld_ready  out  1  load word accepted this cycle when ld_valid is also high.
- ready  out  1  memory in RUN; fetches are accepted.
- req  in  1  fetch request.
- a  in  32  byte address of the fetch.
- rd_valid  out  1  fetch response valid.
- rd  out  DATA_W  fetched word; 0 on fault.
- misalign  out  1  response fault: a[1:0] != 0.
- oob  out  1  response fault: word index >= loaded word count, or a >= 4*DEPTH.

## Operation
- States:
  - EMPTY: reset state. ld_ready=0, ready=0.
  - LOAD: ld_ready=1.
  - RUN: ready=1, ld_ready=0.
- Transitions:
  - ld_start in any state → LOAD, with ptr=0 and count=0.
  - LOAD, on a handshake with ld_last=1 → RUN.
  - LOAD, on a handshake at ptr=DEPTH-1 → RUN. This happens with or without ld_last.
- Load handshake (ld_valid & ld_ready): mem[ptr] ← ld_data, then ptr ← ptr+1 and count ← ptr+1.
- ptr and count are clog2(DEPTH)+1 bits wide; ptr never wraps.
- ld_start has priority over a same-cycle ld_valid; that word is not written.
- ld_valid outside LOAD is ignored.
- Fetch:
  - req is sampled only while ready=1; req in EMPTY or LOAD is dropped with no response.
  - Index = a[clog2(DEPTH)+1:2].
  - Faults are computed at request time.
  - misalign and oob may both be set on one response.
  - Faulted responses return rd=0. The memory itself is not consulted for visible data.
- Memory array is not reset. After reset or a new ld_start, words from the previous load are unreachable because count=0 until they are rewritten.
- Flush: ld_start or reset clears all in-flight fetch pipeline valids. No response is produced for requests accepted before the flush.

## Timing
- Reset values (asynchronous, immediate on reset=0):
  - state=EMPTY, ptr=0, count=0.
  - ld_ready=0, ready=0.
  - rd_valid=0, rd=0, misalign=0, oob=0.
  - All pipeline valids 0.
- Load writes occur on the handshake edge.
- After the final handshake edge, ready=1 in the next cycle, and a fetch to the last word is legal in that same cycle.
- ld_ready=1 from the cycle after ld_start.
- Fetch latency: req accepted at edge N → rd_valid, rd, misalign and oob valid for exactly one cycle after edge N+LAT-1, i.e. visible in cycle N+LAT.
  - LAT=1 is a registered read.
  - Throughput is one request per cycle with no stalls.
- Response outputs other than rd_valid hold their last value when rd_valid=0. rd returns to 0 only on reset.
- ld_start in the same cycle as req: req dropped, and ready falls the next cycle.
- Reset deassertion is synchronised by the system; the block starts acting on the first edge with reset=1.

## Test plan
- Reset, load E3A01002, E3A02003, E1A03211 (ld_last on third):
  - ready=1 the next cycle.
  - Fetch a=0,4,8 back-to-back with LAT=1 → rd_valid on three consecutive cycles, returning E3A01002, E3A02003, E1A03211 with misalign=0 and oob=0.
- Same load, fetch a=0xC → oob=1, rd=0. Fetch a=0x6 → misalign=1, rd=0. Fetch a=0x102 → misalign=1 and oob=1.
- DEPTH=64, stream 64 words (word i = i) without ld_last:
  - Auto RUN after the 64th handshake; ld_ready=0.
  - Further ld_valid is ignored.
  - Fetch a=0xFC → rd=63.
- LAT=3, two fetches in flight, ld_start pulsed:
  - No rd_valid for either fetch.
  - ready=0 and ld_ready=1 the next cycle.
  - Fetch a=0 then gives no response until reload.
- ld_start together with ld_valid (data AAAA0000), then ld_valid BBBB0000 with ld_last → fetch a=0 returns BBBB0000, and count=1.
- reset=0 asserted asynchronously mid-load → all outputs 0 without a clock edge. After release, fetch a=0 gets no response until ld_start and reload.

Source files
------------

// File: rtl/imem_loadable.sv
// Run-time loadable instruction memory with a streaming load port and a
// fully pipelined fetch path of LAT cycles that reports misaligned and
// out-of-range fetches instead of returning undefined data.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_EMPTY | after reset; no program present, loads and fetches ignored
//   S_LOAD  | accepting program words at ptr; fetches dropped
//   S_RUN   | program present; fetches accepted one per cycle
module imem_loadable #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic              ld_last,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ready,
    input  logic              req,
    input  logic [31:0]       a,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd,
    output logic              misalign,
    output logic              oob
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     count_q, count_d;
    logic              ld_hs;
    logic              acc;
    logic [AW-1:0]     idx;
    logic              f_mis;
    logic              f_oob;
    logic [DATA_W-1:0] rd0;

    // Storage is deliberately not reset; count gates visibility instead.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Per-stage fetch pipeline. Stage data only advances behind a valid so
    // the last stage keeps the most recent response while rd_valid is low.
    logic [LAT-1:0]    v_q;
    logic [LAT-1:0]    m_q;
    logic [LAT-1:0]    o_q;
    logic [DATA_W-1:0] d_q [LAT];

    assign ld_ready = (state_q == S_LOAD);
    assign ready    = (state_q == S_RUN);

    // ld_start wins over a same-cycle load word or fetch request.
    assign ld_hs = ld_valid && ld_ready && !ld_start;
    assign acc   = req && ready && !ld_start;

    assign idx   = a[AW+1:2];
    assign f_mis = (a[1:0] != 2'b00);
    assign f_oob = ({1'b0, idx} >= count_q) || (a[31:AW+2] != '0);
    assign rd0   = (f_mis || f_oob) ? '0 : mem_q[idx];

    // Load sequencing: next state, write pointer and loaded word count.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (ld_start) begin
            state_d = S_LOAD;
            ptr_d   = '0;
            count_d = '0;
        end else if (ld_hs) begin
            ptr_d   = ptr_q + PW'(1);
            count_d = ptr_q + PW'(1);
            if (ld_last || (ptr_q == PW'(DEPTH - 1))) begin
                state_d = S_RUN;
            end
        end
    end

    // State, pointer and count registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_EMPTY;
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    // Program word write on the load handshake edge.
    always_ff @(posedge clk) begin
        if (ld_hs) begin
            mem_q[ptr_q[AW-1:0]] <= ld_data;
        end
    end

    // Fetch pipeline; ld_start flushes every in-flight valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= '0;
            m_q <= '0;
            o_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q[0] <= acc;
            if (acc) begin
                d_q[0] <= rd0;
                m_q[0] <= f_mis;
                o_q[0] <= f_oob;
            end
            for (int k = 1; k < LAT; k++) begin
                v_q[k] <= v_q[k-1] && !ld_start;
                if (v_q[k-1] && !ld_start) begin
                    d_q[k] <= d_q[k-1];
                    m_q[k] <= m_q[k-1];
                    o_q[k] <= o_q[k-1];
                end
            end
        end
    end

    assign rd_valid = v_q[LAT-1];
    assign rd       = d_q[LAT-1];
    assign misalign = m_q[LAT-1];
    assign oob      = o_q[LAT-1];

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: a LAT=1 and a LAT=3 instance share stimulus and
// are checked every cycle against a queue-based reference of the load and
// fetch rules, with literal spot checks from the directed scenarios.
module tb_imem_loadable;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_start, ld_valid, ld_last, req;
    logic [31:0] ld_data, a;

    logic        r1_ld_ready, r1_ready, r1_rd_valid, r1_mis, r1_oob;
    logic [31:0] r1_rd;
    logic        r3_ld_ready, r3_ready, r3_rd_valid, r3_mis, r3_oob;
    logic [31:0] r3_rd;

    always #5 clk = ~clk;

    imem_loadable #(.DATA_W(32), .DEPTH(DEPTH), .LAT(1)) u1 (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_last(ld_last), .ld_data(ld_data), .ld_ready(r1_ld_ready),
        .ready(r1_ready), .req(req), .a(a), .rd_valid(r1_rd_valid),
        .rd(r1_rd), .misalign(r1_mis), .oob(r1_oob));

    imem_loadable #(.DATA_W(32), .DEPTH(DEPTH), .LAT(3)) u3 (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_last(ld_last), .ld_data(ld_data), .ld_ready(r3_ld_ready),
        .ready(r3_ready), .req(req), .a(a), .rd_valid(r3_rd_valid),
        .rd(r3_rd), .misalign(r3_mis), .oob(r3_oob));

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        m;
        logic        o;
    } resp_t;

    resp_t       q1[$];
    resp_t       q3[$];
    int          tests = 0;
    int          fails = 0;
    int          edge_n = 0;
    int          m_state;          // 0 EMPTY, 1 LOAD, 2 RUN
    int          m_ptr;
    int          m_cnt;
    logic [31:0] mmem [DEPTH];
    logic [31:0] h_d [2];
    logic        h_m [2];
    logic        h_o [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        q1.delete();
        q3.delete();
        for (int k = 0; k < 2; k++) begin
            h_d[k] = '0;
            h_m[k] = 1'b0;
            h_o[k] = 1'b0;
        end
    endtask

    task automatic model_step();
        resp_t r;
        int    idx;
        bit    mis, oob;
        if (m_state == 2 && req && !ld_start) begin
            idx = int'(a[7:2]);
            mis = (a[1:0] != 2'b00);
            oob = (a >= 32'(4 * DEPTH)) || (idx >= m_cnt);
            r.d = (mis || oob) ? 32'h0 : mmem[idx];
            r.m = mis;
            r.o = oob;
            r.due = edge_n;
            q1.push_back(r);
            r.due = edge_n + 2;
            q3.push_back(r);
        end
        if (ld_start) begin
            q1.delete();
            q3.delete();
            m_state = 1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (m_state == 1 && ld_valid) begin
            mmem[m_ptr] = ld_data;
            m_ptr++;
            m_cnt = m_ptr;
            if (ld_last || m_ptr == DEPTH) m_state = 2;
        end
    endtask

    task automatic chk_inst(input int k, input logic v, input logic [31:0] d,
                            input logic m, input logic o);
        resp_t e;
        bit    have;
        string tag;
        have = 1'b0;
        tag  = (k == 0) ? "L1" : "L3";
        if (k == 0) begin
            if (q1.size() > 0 && q1[0].due == edge_n) begin
                e = q1.pop_front();
                have = 1'b1;
            end
        end else begin
            if (q3.size() > 0 && q3[0].due == edge_n) begin
                e = q3.pop_front();
                have = 1'b1;
            end
        end
        if (have) begin
            h_d[k] = e.d;
            h_m[k] = e.m;
            h_o[k] = e.o;
        end
        check({tag, " rd_valid"}, 32'(v), 32'(have));
        check({tag, " rd"},       d,      h_d[k]);
        check({tag, " misalign"}, 32'(m), 32'(h_m[k]));
        check({tag, " oob"},      32'(o), 32'(h_o[k]));
    endtask

    // Reference update on every edge, then compare just after it.
    always @(posedge clk) begin
        edge_n++;
        if (!reset) model_reset();
        else        model_step();
        #1;
        check("L1 ready",    32'(r1_ready),    32'(m_state == 2));
        check("L1 ld_ready", 32'(r1_ld_ready), 32'(m_state == 1));
        check("L3 ready",    32'(r3_ready),    32'(m_state == 2));
        check("L3 ld_ready", 32'(r3_ld_ready), 32'(m_state == 1));
        chk_inst(0, r1_rd_valid, r1_rd, r1_mis, r1_oob);
        chk_inst(1, r3_rd_valid, r3_rd, r3_mis, r3_oob);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        req      = 1'b0;
    endtask

    initial begin
        idle();
        reset   = 1'b0;
        a       = '0;
        ld_data = '0;
        repeat (3) step();
        check("rst ready",    32'(r1_ready),    32'd0);
        check("rst ld_ready", 32'(r1_ld_ready), 32'd0);
        check("rst rd_valid", 32'(r3_rd_valid), 32'd0);
        check("rst rd",       r3_rd,            32'h0);
        reset = 1'b1;
        step();

        // Three-word program with ld_last on the third word.
        ld_start = 1'b1; step(); ld_start = 1'b0;
        check("ld_ready after start", 32'(r1_ld_ready), 32'd1);
        ld_valid = 1'b1;
        ld_data = 32'hE3A01002; step();
        ld_data = 32'hE3A02003; step();
        ld_data = 32'hE1A03211; ld_last = 1'b1; step();
        ld_valid = 1'b0; ld_last = 1'b0;
        check("ready after last", 32'(r1_ready), 32'd1);
        check("ld_ready after last", 32'(r1_ld_ready), 32'd0);
        req = 1'b1;
        a = 32'h0; step();
        check("fetch0 valid", 32'(r1_rd_valid), 32'd1);
        check("fetch0 rd", r1_rd, 32'hE3A01002);
        a = 32'h4; step();
        check("fetch4 rd", r1_rd, 32'hE3A02003);
        check("L3 not yet", 32'(r3_rd_valid), 32'd0);
        a = 32'h8; step();
        check("fetch8 rd", r1_rd, 32'hE1A03211);
        check("L3 fetch0 valid", 32'(r3_rd_valid), 32'd1);
        check("L3 fetch0 rd", r3_rd, 32'hE3A01002);
        a = 32'hC; step();
        check("fetchC oob", 32'(r1_oob), 32'd1);
        check("fetchC rd", r1_rd, 32'h0);
        a = 32'h6; step();
        check("fetch6 mis", 32'(r1_mis), 32'd1);
        check("fetch6 oob", 32'(r1_oob), 32'd0);
        a = 32'h102; step();
        check("fetch102 mis", 32'(r1_mis), 32'd1);
        check("fetch102 oob", 32'(r1_oob), 32'd1);
        req = 1'b0;
        repeat (3) step();

        // ld_start beats a same-cycle load word.
        ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'hAAAA0000; step();
        ld_start = 1'b0; ld_data = 32'hBBBB0000; ld_last = 1'b1; step();
        ld_valid = 1'b0; ld_last = 1'b0;
        req = 1'b1; a = 32'h0; step();
        check("start+valid rd", r1_rd, 32'hBBBB0000);
        a = 32'h4; step();
        check("count one oob", 32'(r1_oob), 32'd1);

        // Request dropped when ld_start arrives in the same cycle.
        a = 32'h0; ld_start = 1'b1; step();
        ld_start = 1'b0; req = 1'b0;
        check("req+start no resp", 32'(r1_rd_valid), 32'd0);
        check("req+start ready", 32'(r1_ready), 32'd0);
        check("req+start ld_ready", 32'(r1_ld_ready), 32'd1);

        // Full-depth load without ld_last.
        ld_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ld_data = 32'(i);
            step();
        end
        check("full auto run", 32'(r1_ready), 32'd1);
        check("full ld_ready", 32'(r1_ld_ready), 32'd0);
        ld_data = 32'hDEADBEEF; step();
        ld_valid = 1'b0;
        req = 1'b1; a = 32'hFC; step();
        check("fetchFC rd", r1_rd, 32'd63);
        a = 32'h0; step();
        check("word0 intact", r1_rd, 32'd0);
        check("word0 oob", 32'(r1_oob), 32'd0);

        // Flush of LAT=3 fetches in flight.
        a = 32'h4; step();
        a = 32'h8; step();
        req = 1'b0; ld_start = 1'b1; step();
        ld_start = 1'b0;
        check("flush ready", 32'(r1_ready), 32'd0);
        check("flush ld_ready", 32'(r1_ld_ready), 32'd1);
        check("flush L3 none", 32'(r3_rd_valid), 32'd0);
        step();
        check("flush L3 none2", 32'(r3_rd_valid), 32'd0);
        req = 1'b1; a = 32'h0;
        repeat (3) begin
            step();
            check("load fetch L1", 32'(r1_rd_valid), 32'd0);
            check("load fetch L3", 32'(r3_rd_valid), 32'd0);
        end
        req = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_data = 32'h5000_0000 + 32'(i);
            ld_last = (i == 2);
            step();
        end
        idle();
        req = 1'b1; a = 32'h8; step();
        req = 1'b0; repeat (3) step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            ld_start = ($urandom_range(0, 99) == 0);
            ld_valid = ($urandom_range(0, 1) == 1);
            ld_last  = ($urandom_range(0, 15) == 0);
            ld_data  = $urandom;
            req      = ($urandom_range(0, 3) != 0);
            a        = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 300));
            step();
        end
        idle();
        repeat (4) step();

        // Asynchronous reset in the middle of a load.
        ld_start = 1'b1; step(); ld_start = 1'b0;
        ld_valid = 1'b1;
        ld_data = 32'h11111111; step();
        ld_data = 32'h22222222; ld_last = 1'b1; step();
        idle();
        req = 1'b1; a = 32'h4; step();
        req = 1'b0; repeat (3) step();
        check("pre-reset L3 rd", r3_rd, 32'h22222222);
        ld_start = 1'b1; step(); ld_start = 1'b0;
        ld_valid = 1'b1; ld_data = 32'h33333333; step();
        #3;
        reset = 1'b0;
        #1;
        check("async L1 ld_ready", 32'(r1_ld_ready), 32'd0);
        check("async L1 ready",    32'(r1_ready),    32'd0);
        check("async L1 rd_valid", 32'(r1_rd_valid), 32'd0);
        check("async L1 rd",       r1_rd,            32'h0);
        check("async L1 mis",      32'(r1_mis),      32'd0);
        check("async L1 oob",      32'(r1_oob),      32'd0);
        check("async L3 ld_ready", 32'(r3_ld_ready), 32'd0);
        check("async L3 rd",       r3_rd,            32'h0);
        idle();
        step();
        reset = 1'b1;
        step();
        req = 1'b1; a = 32'h0;
        repeat (4) begin
            step();
            check("post-reset L1 none", 32'(r1_rd_valid), 32'd0);
            check("post-reset L3 none", 32'(r3_rd_valid), 32'd0);
        end
        req = 1'b0;
        ld_start = 1'b1; step(); ld_start = 1'b0;
        ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'hCAFE0001; step();
        idle();
        req = 1'b1; a = 32'h0; step();
        check("reload rd", r1_rd, 32'hCAFE0001);
        req = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
